uart_tx: RTL
============

# uart_tx

Serial UART transmitter for the pipelined CPU's I/O path. It takes the result byte produced by the register-file/UART logic (`uart_result_data`) and shifts it out on the TX line as 8N1 frames. It is the outbound counterpart of the receive path that delivers `uart_rx_data`/`uart_signal` into ID. A one-entry holding buffer lets the core issue a second byte while a frame is in flight.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 10416: clk cycles per bit (100 MHz / 9600 baud); legal range ≥ 2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tx_start`  in  1  single-cycle request to send `tx_data`.
- `tx_data`  in  8  byte to send; sampled only in a cycle where `tx_start` is 1.
- `tx`  out  1  serial line; idles high; registered.
- `tx_busy`  out  1  1 whenever a frame is on the line (state ≠ IDLE).
- `buf_full`  out  1  holding buffer occupied.
- `tx_done`  out  1  one-cycle pulse at frame completion.
- `tx_overrun`  out  1  one-cycle pulse: a request was dropped.

## Operation
- Frame format: start bit (0), then `d[0]`…`d[7]` LSB first, then a stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- FSM states: IDLE → START → DATA → STOP.
  - STOP → IDLE when the buffer is empty.
  - STOP → START when the buffer is full (back-to-back frames, no idle gap).
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and reloads to 0 on every state or bit change. The bit index runs 0..7 in DATA.
- Accept rules for `tx_start`:
  - IDLE: latch `tx_data` into the shift register and go to START.
  - Busy, buffer empty: latch into the buffer; `buf_full` becomes 1.
  - Busy, buffer full, and not the final STOP cycle: drop the request and pulse `tx_overrun`. Shift register and buffer are unchanged.
  - Final STOP cycle, buffer empty: the new byte becomes the next frame directly.
  - Final STOP cycle, buffer full: the buffer byte moves to the shift register and the new byte enters the buffer. `buf_full` stays 1 and there is no overrun.
- Reset values: `tx`=1, `tx_busy`=0, `buf_full`=0, `tx_done`=0, `tx_overrun`=0, state IDLE, counters 0.
- Reset mid-frame: the frame is abandoned, `tx` goes high asynchronously, and buffer contents are discarded.

## Timing
- Accept at edge E0, meaning `tx_start` is high in the cycle before E0.
- `tx`=0 and `tx_busy`=1 in the cycle following E0.
- A frame occupies exactly 10·`CLKS_PER_BIT` cycles starting that cycle.
- `tx_done` is high for exactly one cycle: the cycle after the last stop-bit cycle.
  - If a next frame is pending, its start bit occupies that same cycle.
  - Otherwise `tx_busy` is 0 in that cycle.
- `tx_overrun` is high in the cycle after the dropping edge.
- `tx_busy` has no glitches between back-to-back frames.
- `tx_data` need not be held after the accepting edge.

## Structure
- Shared include `uart_defs.vh` holds:
  - the FSM state encodings (2-bit: IDLE=0, START=1, DATA=2, STOP=3);
  - the frame constants (8 data bits, 1 stop bit);
  - the default `CLKS_PER_BIT`.
- The receive path uses the same include.
- One natural sub-module is `uart_baud_counter`: a parameterised counter with `clear` input and `tick` output (tick on count = `CLKS_PER_BIT`-1). Everything else stays in `uart_tx`.
- Expected size: about 150–250 lines.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **Reset:** hold `rst_n`=0 with `tx_start`=1 → `tx`=1, all flags 0. Release reset → no frame until a fresh `tx_start`.
- **Single byte 0x55:** accept at E0 → `tx` = 0,1,0,1,0,1,0,1,0,1 for 4 cycles each (40 cycles) → `tx_done` pulses on cycle 41, then `tx_busy`=0.
- **Back-to-back 0xA3 then 0x0F:** 0x0F is issued 10 cycles into frame 1 → `buf_full`=1. The second start bit begins in the `tx_done` cycle of frame 1, with no idle bit. Decoded stream is 0xA3, 0x0F; two `tx_done` pulses 40 cycles apart.
- **Overrun:** three requests 0x11, 0x22, 0x33 mid-frame → 0x33 dropped with one `tx_overrun` pulse; line carries only 0x11, 0x22.
- **Final-stop-cycle collision:** `tx_start`(0x77) in the final STOP cycle with buffer full (0x22) → 0x22 sent next, 0x77 buffered, no overrun.
- **Reset mid-frame:** assert `rst_n`=0 during bit 3 of 0xFF → `tx`=1 immediately; after release, `tx_busy`=0 and `buf_full`=0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Brief    : Shared UART definitions: FSM state encodings, frame constants
//            and the default bit period. Used by both TX and RX paths.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  // Transmitter FSM states (2-bit encoding shared with the receive path)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Frame shape: 8 data bits, 1 stop bit, no parity
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  // Index of the last data bit, used to leave the DATA state
  localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = BIT_IDX_W'(DATA_BITS - 1);

  // 100 MHz core clock at 9600 baud
  localparam int DEFAULT_CLKS_PER_BIT = 10416;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_baud_counter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_baud_counter
// Brief    : Bit-period counter. Counts 0..CLKS_PER_BIT-1, pulses tick on
//            the last count and wraps to 0; clear holds it at 0.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_baud_counter
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  // Next count: restart on clear or at the end of each bit period
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_tx_baud_counter
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter with a one-entry holding buffer so the core
//            can queue a second byte while a frame is on the line.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       buf_full,
  output logic       tx_done,
  output logic       tx_overrun
);

  tx_state_e              state_q,      state_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q,    bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q,      shift_d;
  logic [DATA_BITS-1:0]   buf_q,        buf_d;
  logic                   buf_full_q,   buf_full_d;
  logic                   tx_q,         tx_d;
  logic                   tx_done_q,    tx_done_d;
  logic                   tx_overrun_q, tx_overrun_d;

  logic baud_tick;
  logic final_stop;

  // Counter is held at zero while idle so the start bit gets a full period;
  // every other state change happens on a tick, where it wraps by itself.
  uart_tx_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == ST_IDLE),
    .tick  (baud_tick)
  );

  // Last cycle of the stop bit: the frame boundary where a new frame may begin
  assign final_stop = (state_q == ST_STOP) && baud_tick;

  // Next-state, line level, shift register and holding-buffer control
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    tx_d         = tx_q;
    tx_done_d    = 1'b0;
    tx_overrun_d = 1'b0;

    // Requests arriving mid-frame go to the buffer or are dropped
    if (tx_start && (state_q != ST_IDLE) && !final_stop) begin
      if (!buf_full_q) begin
        buf_d      = tx_data;
        buf_full_d = 1'b1;
      end else begin
        tx_overrun_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shift_d = tx_data;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == LAST_BIT_IDX) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (baud_tick) begin
          tx_done_d = 1'b1;
          if (buf_full_q) begin
            // Buffered byte goes next; a coincident request refills the buffer
            shift_d = buf_q;
            tx_d    = 1'b0;
            state_d = ST_START;
            if (tx_start) begin
              buf_d = tx_data;
            end else begin
              buf_full_d = 1'b0;
            end
          end else if (tx_start) begin
            shift_d = tx_data;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any frame and empties the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      tx_q         <= 1'b1;
      tx_done_q    <= 1'b0;
      tx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      tx_q         <= tx_d;
      tx_done_q    <= tx_done_d;
      tx_overrun_q <= tx_overrun_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = (state_q != ST_IDLE);
  assign buf_full   = buf_full_q;
  assign tx_done    = tx_done_q;
  assign tx_overrun = tx_overrun_q;

endmodule : uart_tx
`default_nettype wire
